// File: rtl/tail_light_request_arbiter.sv
// -----------------------------------------------------------------------------
// tail_light_request_arbiter
//
// Conditions the raw brake pedal and turn stalk switches and arbitrates
// between left and right turn requests for the tail light sequencer. When both
// turn sides are requested they alternate in fixed-length slots separated by a
// one-cycle gap in which neither turn output is active.
//
// Build option:
//   ARB_DEBOUNCE_EN  defined   -> each synchronized input goes through a
//                                 counter-based debounce filter.
//                    undefined -> filtered value is the synchronized value and
//                                 DEBOUNCE_CYCLES has no effect.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing cycles before a filter flips (1..15)
//   SLOT_CYCLES      cycles a side holds the grant under contention (2..255)
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   brake_in    in   raw brake pedal switch (asynchronous)
//   left_req    in   raw left turn stalk (asynchronous)
//   right_req   in   raw right turn stalk (asynchronous)
//   brake       out  registered brake command
//   turn_left   out  registered left turn command
//   turn_right  out  registered right turn command
//   grant       out  arbiter state: 00 idle, 01 left, 10 right, 11 gap
// -----------------------------------------------------------------------------
module tail_light_request_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SLOT_CYCLES     = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       brake_in,
    input  logic       left_req,
    input  logic       right_req,
    output logic       brake,
    output logic       turn_left,
    output logic       turn_right,
    output logic [1:0] grant
);

    // Elaboration-time parameter range guards.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 1..15");
    end
    if (SLOT_CYCLES < 2 || SLOT_CYCLES > 255) begin : g_bad_slot
        $error("SLOT_CYCLES must be in 2..255");
    end

    localparam logic [7:0] SlotLast = 8'(SLOT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StLeft  = 2'b01,
        StRight = 2'b10,
        StGap   = 2'b11
    } arb_state_e;

    // Bit order for all per-input vectors: [0] brake, [1] left, [2] right.
    logic [2:0] raw;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] filt;

    assign raw = {right_req, left_req, brake_in};

    // Two-flop synchronizer ahead of everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef ARB_DEBOUNCE_EN
    localparam logic [3:0] DbLast = 4'(DEBOUNCE_CYCLES - 1);

    logic [2:0]      filt_q;
    logic [2:0]      filt_d;
    logic [2:0][3:0] db_cnt_q;
    logic [2:0][3:0] db_cnt_d;

    // Counter runs only while the synchronized value disagrees with the
    // filtered value; any agreement or a flip restarts it from zero.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    filt_d[i] = ~filt_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q   <= '0;
            db_cnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    logic       left_f;
    logic       right_f;
    arb_state_e state_q;
    arb_state_e state_d;
    arb_state_e idle_pick;
    logic       last_grant_q;
    logic       last_grant_d;
    logic [7:0] slot_q;
    logic [7:0] slot_d;
    logic       brake_q;
    logic       turn_left_q;
    logic       turn_right_q;

    assign left_f  = filt[1];
    assign right_f = filt[2];

    // Decision taken from IDLE and, one cycle later, from GAP. Under
    // contention the side that was not served last wins.
    always_comb begin
        idle_pick = StIdle;
        if (left_f && !right_f) begin
            idle_pick = StLeft;
        end else if (!left_f && right_f) begin
            idle_pick = StRight;
        end else if (left_f && right_f) begin
            idle_pick = last_grant_q ? StLeft : StRight;
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle, StGap: begin
                state_d = idle_pick;
            end
            StLeft: begin
                if (!left_f) begin
                    state_d = right_f ? StGap : StIdle;
                end else if (!right_f) begin
                    slot_d = '0;
                end else if (slot_q == SlotLast) begin
                    state_d = StGap;
                end else begin
                    slot_d = slot_q + 8'd1;
                end
            end
            StRight: begin
                if (!right_f) begin
                    state_d = left_f ? StGap : StIdle;
                end else if (!left_f) begin
                    slot_d = '0;
                end else if (slot_q == SlotLast) begin
                    state_d = StGap;
                end else begin
                    slot_d = slot_q + 8'd1;
                end
            end
        endcase

        // Every state entry starts a fresh slot.
        if (state_d != state_q) begin
            slot_d = '0;
            if (state_d == StLeft) begin
                last_grant_d = 1'b0;
            end else if (state_d == StRight) begin
                last_grant_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            slot_q       <= '0;
            brake_q      <= 1'b0;
            turn_left_q  <= 1'b0;
            turn_right_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            slot_q       <= slot_d;
            brake_q      <= filt[0];
            // Decoded from next state so the turn outputs line up with grant.
            turn_left_q  <= (state_d == StLeft);
            turn_right_q <= (state_d == StRight);
        end
    end

    assign brake      = brake_q;
    assign turn_left  = turn_left_q;
    assign turn_right = turn_right_q;
    assign grant      = state_q;

endmodule

// File: tb/tb_tail_light_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tail_light_request_arbiter
//
// Self-checking bench: directed scenarios plus randomized request patterns,
// compared every cycle against a behavioural model of the input conditioning
// and the turn arbitration rules.
// -----------------------------------------------------------------------------
module tb_tail_light_request_arbiter;

    localparam int DEB  = 4;
    localparam int SLOT = 80;
`ifdef ARB_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif
    localparam int LAT = DB_ON ? DEB + 3 : 3;
    localparam bit [15:0] DB_MASK = 16'((1 << DEB) - 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       brake_in = 1'b0;
    logic       left_req = 1'b0;
    logic       right_req = 1'b0;
    logic       brake;
    logic       turn_left;
    logic       turn_right;
    logic [1:0] grant;

    tail_light_request_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .SLOT_CYCLES    (SLOT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .brake_in  (brake_in),
        .left_req  (left_req),
        .right_req (right_req),
        .brake     (brake),
        .turn_left (turn_left),
        .turn_right(turn_right),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Inputs pass through two cycles of delay; a filtered value flips once the
    // last DEB synchronized samples all disagree with it. Arbitration states:
    // 0 idle, 1 left, 2 right, 3 gap.
    bit [15:0] m_hist [3];
    bit [2:0]  m_s1;
    bit [2:0]  m_s2;
    bit [2:0]  m_filt;
    int        m_state;
    int        m_last;
    int        m_cont;
    bit        e_brake;
    bit        e_tl;
    bit        e_tr;
    int        e_grant;

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        m_filt = '0;
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
        m_state = 0;
        m_last = 1;
        m_cont = 0;
        e_brake = 0;
        e_tl = 0;
        e_tr = 0;
        e_grant = 0;
    endtask

    task automatic model_step(input bit b, input bit l_raw, input bit r_raw);
        bit [2:0] eff;
        bit l;
        bit r;
        int pick;
        int ns;
        eff = DB_ON ? m_filt : m_s2;
        l = eff[1];
        r = eff[2];
        if (l && r) pick = (m_last == 1) ? 1 : 2;
        else if (l) pick = 1;
        else if (r) pick = 2;
        else pick = 0;
        case (m_state)
            1: begin
                if (!l) ns = r ? 3 : 0;
                else if (r && m_cont == SLOT - 1) ns = 3;
                else ns = 1;
            end
            2: begin
                if (!r) ns = l ? 3 : 0;
                else if (l && m_cont == SLOT - 1) ns = 3;
                else ns = 2;
            end
            default: ns = pick;
        endcase
        // m_cont = contended cycles already spent in the current slot.
        if (ns != m_state) m_cont = 0;
        else if (l && r) m_cont++;
        else m_cont = 0;
        if (ns == 1 && m_state != 1) m_last = 0;
        if (ns == 2 && m_state != 2) m_last = 1;
        m_state = ns;
        for (int i = 0; i < 3; i++) begin
            m_hist[i] = {m_hist[i][14:0], m_s2[i]};
            if (m_filt[i] ? ((m_hist[i] & DB_MASK) == 16'd0)
                          : ((m_hist[i] & DB_MASK) == DB_MASK)) begin
                m_filt[i] = ~m_filt[i];
            end
        end
        m_s2 = m_s1;
        m_s1 = {r_raw, l_raw, b};
        e_brake = eff[0];
        e_grant = ns;
        e_tl = (ns == 1);
        e_tr = (ns == 2);
    endtask

    // ---------------- stimulus helpers (all start and end on a negedge) -----
    task automatic cycle(input bit b, input bit l, input bit r);
        brake_in = b;
        left_req = l;
        right_req = r;
        @(posedge clk);
        model_step(b, l, r);
        #1;
        check_eq("grant", grant, e_grant);
        check_eq("turn_left", turn_left, e_tl);
        check_eq("turn_right", turn_right, e_tr);
        check_eq("brake", brake, e_brake);
        check_eq("turn_excl", turn_left & turn_right, 0);
        @(negedge clk);
    endtask

    task automatic hard_reset(input bit b, input bit l, input bit r);
        brake_in = b;
        left_req = l;
        right_req = r;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_grant", grant, 0);
        check_eq("rst_turn_left", turn_left, 0);
        check_eq("rst_turn_right", turn_right, 0);
        check_eq("rst_brake", brake, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycles until brake (use_brake) or grant first equals want; must be LAT.
    task automatic wait_for(input string tag, input bit use_brake, input int want,
                            input bit b, input bit l, input bit r);
        int got;
        got = -1;
        for (int k = 1; k <= LAT + 10; k++) begin
            cycle(b, l, r);
            if ((use_brake ? int'(brake) : int'(grant)) == want) begin
                got = k;
                break;
            end
        end
        check_eq(tag, got, LAT);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int  seen;
    int  prev;
    int  run;
    int  first;
    int  gaps;
    int  len;
    bit  bb;
    bit  rb;
    bit  rl;
    bit  rr;

    initial begin
        model_reset();
        @(negedge clk);
        hard_reset(0, 0, 0);

        // Held left request: latency to grant.
        wait_for("lat_left", 0, 1, 0, 1, 0);
        repeat (LAT + 4) cycle(0, 0, 0);

        // Short left pulse.
        seen = 0;
        for (int k = 0; k < DEB - 1; k++) begin
            cycle(0, 1, 0);
            seen |= int'(turn_left);
        end
        for (int k = 0; k < LAT + 4; k++) begin
            cycle(0, 0, 0);
            seen |= int'(turn_left);
        end
        check_eq("short_pulse", seen, DB_ON ? 0 : 1);

        // Both raised together: alternation with brake toggling alongside.
        hard_reset(0, 0, 0);
        prev = 0;
        run = 0;
        first = -1;
        for (int k = 0; k < 4 * (SLOT + 1) + LAT; k++) begin
            bb = ((k / 23) % 2) == 1;
            cycle(bb, 1, 1);
            if (first < 0 && grant != 2'b00) first = int'(grant);
            if (int'(grant) == prev) begin
                run++;
            end else begin
                if (prev == 1 || prev == 2) check_eq("slot_len", run, SLOT);
                if (prev == 3) check_eq("gap_len", run, 1);
                prev = int'(grant);
                run = 1;
            end
        end
        check_eq("first_grant", first, 1);

        // Right alone, left briefly contends then drops: right is kept.
        hard_reset(0, 0, 0);
        wait_for("lat_right", 0, 2, 0, 0, 1);
        repeat (40) cycle(0, 1, 1);
        repeat (LAT + 10) cycle(0, 0, 1);
        check_eq("right_kept", grant, 2);
        repeat (SLOT + LAT + 5) cycle(0, 1, 1);

        // Left drops while right held: one gap then right.
        hard_reset(0, 0, 0);
        wait_for("lat_left2", 0, 1, 0, 1, 0);
        repeat (10) cycle(0, 1, 1);
        gaps = 0;
        for (int k = 0; k < LAT + 6; k++) begin
            cycle(0, 0, 1);
            if (grant == 2'b11) gaps++;
        end
        check_eq("gap_once", gaps, 1);
        check_eq("then_right", grant, 2);

        // Reset mid-slot in right, right held through and after reset.
        repeat (20) cycle(0, 1, 1);
        hard_reset(0, 0, 1);
        wait_for("lat_rst_right", 0, 2, 0, 0, 1);

        // Brake latency while right is granted.
        wait_for("lat_brake", 1, 1, 1, 0, 1);

        // Randomized held patterns.
        for (int s = 0; s < 250; s++) begin
            rb = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 3 * DEB));
            repeat (len) cycle(rb, rl, rr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tail_light_request_arbiter.md
TAIL_LIGHT_REQUEST_ARBITER -- requirements
Module: tail_light_request_arbiter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a raw input must differ from its filtered value before the filtered value flips; legal range 1..15.
REQ-002 SHALL have parameter SLOT_CYCLES, default 80: cycles a turn side holds the grant while both sides request; legal range 2..255.
REQ-003 SHALL have port clk  input  1  sole clock, all flops on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port brake_in  input  1  raw brake pedal switch, asynchronous to clk.
REQ-006 SHALL have port left_req  input  1  raw left turn stalk, asynchronous to clk.
REQ-007 SHALL have port right_req  input  1  raw right turn stalk, asynchronous to clk.
REQ-008 SHALL have port brake  output  1  registered brake command to the tail light sequencer.
REQ-009 SHALL have port turn_left  output  1  registered left turn command to the sequencer.
REQ-010 SHALL have port turn_right  output  1  registered right turn command to the sequencer.
REQ-011 SHALL have port grant  output  2  registered arbiter state: 00 IDLE, 01 LEFT, 10 RIGHT, 11 GAP.

Function
REQ-012 SHALL pass each raw input through a 2-flop synchronizer before any other logic.
REQ-013 SHALL debounce each synchronized input independently with a 4-bit counter: counter clears whenever synchronized value equals filtered value; filtered value flips and counter clears when counter reaches DEBOUNCE_CYCLES-1 while values differ.
REQ-014 SHALL have an arbiter FSM with states IDLE, LEFT, RIGHT, GAP, plus a last_grant bit (0 = left served last, 1 = right served last) and an 8-bit slot counter.
REQ-015 IDLE: left only -> LEFT; right only -> RIGHT; both -> side opposite last_grant; neither -> stay IDLE.
REQ-016 LEFT: left dropped -> GAP if right filtered high, else IDLE; left held with right low -> stay, slot counter held at 0; both held -> slot counter increments, and at SLOT_CYCLES-1 -> GAP.
REQ-017 RIGHT: mirror of REQ-016 with sides swapped.
REQ-018 GAP: lasts exactly one cycle with both turn outputs low, then evaluates as IDLE (REQ-015).
REQ-019 SHALL update last_grant on every entry into LEFT (to 0) or RIGHT (to 1), and clear the slot counter on every state entry.
REQ-020 turn_left SHALL be 1 only in LEFT, turn_right only in RIGHT; both SHALL never be 1 in the same cycle.
REQ-021 brake SHALL equal the filtered brake value, independent of the arbiter FSM.
REQ-022 Latency: a raw change stable for at least DEBOUNCE_CYCLES+3 cycles SHALL appear on outputs DEBOUNCE_CYCLES+3 cycles after first sampling (2 sync + DEBOUNCE_CYCLES filter + 1 output register).
REQ-023 A raw pulse shorter than DEBOUNCE_CYCLES cycles after synchronization SHALL produce no output change.

Reset
REQ-024 While rst_n low, all outputs SHALL be 0, FSM SHALL be IDLE, last_grant SHALL be 1, and all sync flops, filtered values and counters SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL clear outputs within the same cycle, without waiting for clk.
REQ-026 After rst_n deasserts, operation SHALL resume from IDLE; a request already held SHALL be granted after the normal REQ-022 latency.

Configuration
REQ-027 Macro ARB_DEBOUNCE_EN defined: debounce filters of REQ-013 present.
REQ-028 Macro ARB_DEBOUNCE_EN undefined: filtered value SHALL equal the synchronized value, latency 3 cycles, DEBOUNCE_CYCLES ignored; all other behaviour unchanged.

Verification
REQ-029 Debounce on, left_req high held -> turn_left=1, grant=01 exactly 7 cycles after first sampling; 3-cycle left_req pulse -> no output change.
REQ-030 Left and right raised in the same cycle after reset -> LEFT granted first; with both held, 80 cycles LEFT, 1 cycle GAP, 80 cycles RIGHT, 1 cycle GAP, repeating.
REQ-031 In RIGHT with only right held, left rises and drops after 40 filtered cycles -> RIGHT never relinquished; slot counter returns to 0.
REQ-032 In LEFT, left drops while right held -> one GAP cycle (both turn outputs 0), then RIGHT.
REQ-033 brake_in toggled during LEFT alternation -> brake follows with 7-cycle latency; turn_left/turn_right sequence unaffected.
REQ-034 rst_n pulsed low mid-slot in RIGHT -> all outputs 0 immediately; after release with right held, RIGHT regranted after 7 cycles.
